// File: rtl/dot_operand_streamer_pkg.sv
// Shared definitions for the dot-product operand streamer: beat geometry
// derivations, FIFO sizing and the controller state encoding.
package dot_operand_streamer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int FIFO_DEPTH = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int lanes_of(input int parallel, input int bus_width);
    return parallel * bus_width;
  endfunction

  function automatic int beats_of(input int pixel_n, input int lanes);
    return (pixel_n + lanes - 1) / lanes;
  endfunction

  localparam int FIFO_CNT_W = clog2(FIFO_DEPTH + 1);
  localparam int FIFO_PTR_W = (clog2(FIFO_DEPTH) < 1) ? 1 : clog2(FIFO_DEPTH);

endpackage

// File: rtl/dot_operand_streamer_beat_fifo2.sv
// Two-entry synchronous FIFO holding packed beats between the memory read
// stage and the engine-facing output.
module beat_fifo2
  import dot_operand_streamer_pkg::*;
#(
  parameter int W = 59
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [W-1:0]          push_data,
  input  logic                  pop,
  output logic [W-1:0]          head,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  empty
);

  logic [W-1:0]          mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count < FIFO_CNT_W'(FIFO_DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= (rd_ptr == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
    end
  end

  // Storage carries data only; occupancy is tracked by the control registers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dot_operand_streamer.sv
// Streams PIXEL_N pixel/weight pairs from two synchronous-read memories to the
// dot-product engine as LANES-wide beats with zero-fill and end-of-vector flag.
module dot_operand_streamer
  import dot_operand_streamer_pkg::*;
#(
  parameter int PIXEL_N     = 10,
  parameter int WEIGHT_SIZE = 19,
  parameter int PIXEL_SIZE  = 10,
  parameter int PARALLEL    = 2,
  parameter int BUS_WIDTH   = 1,
  parameter int ADDR_W      = 8,
  localparam int LANES      = lanes_of(PARALLEL, BUS_WIDTH)
) (
  input  logic                         clk,
  input  logic                         GlobalReset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         mem_en,
  output logic [ADDR_W-1:0]            mem_addr,
  input  logic [LANES*PIXEL_SIZE-1:0]  pix_rdata,
  input  logic [LANES*WEIGHT_SIZE-1:0] wgt_rdata,
  output logic [LANES*PIXEL_SIZE-1:0]  Pixels,
  output logic [LANES*WEIGHT_SIZE-1:0] Weights,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last
);

  localparam int BEATS = beats_of(PIXEL_N, LANES);
  localparam int PW    = LANES * PIXEL_SIZE;
  localparam int WW    = LANES * WEIGHT_SIZE;
  localparam int EW    = PW + WW + 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(BEATS - 1);

  state_t                  state_q;
  state_t                  state_d;
  logic [CNT_W-1:0]        issue_cnt;
  logic                    cnt_clr;
  logic                    issue_ok;
  logic [FIFO_CNT_W-1:0]   occ;

  logic                    vld_p1;
  logic [CNT_W-1:0]        beat_p1;

  logic [EW-1:0]           push_data;
  logic [EW-1:0]           fifo_head;
  logic [FIFO_CNT_W-1:0]   fifo_count;
  logic                    fifo_empty;
  logic                    head_last;
  logic                    xfer;

  // Lanes past the end of the vector are zeroed so a partial last beat
  // contributes nothing downstream; the last-beat flag rides with the entry.
  function automatic logic [EW-1:0] pack_beat(input logic [CNT_W-1:0] beat,
                                              input logic [PW-1:0]    pix,
                                              input logic [WW-1:0]    wgt);
    logic [PW-1:0] p;
    logic [WW-1:0] w;
    p = pix;
    w = wgt;
    for (int j = 0; j < LANES; j++) begin
      if (int'(beat) * LANES + j >= PIXEL_N) begin
        p[j*PIXEL_SIZE +: PIXEL_SIZE]   = '0;
        w[j*WEIGHT_SIZE +: WEIGHT_SIZE] = '0;
      end
    end
    return {(beat == LAST_C), p, w};
  endfunction

  assign head_last = fifo_head[EW-1];
  assign out_valid = !fifo_empty;
  assign xfer      = out_valid && out_ready;

  // Occupancy as seen after this cycle's pop, so a steady stream keeps issuing
  // every cycle while never holding more than two beats in FIFO plus flight.
  always_comb begin
    occ      = fifo_count - FIFO_CNT_W'(xfer) + FIFO_CNT_W'(vld_p1);
    issue_ok = (issue_cnt < BEATS_C) && (occ < FIFO_CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) state_q <= IDLE;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    mem_en  = 1'b0;
    done    = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_clr = 1'b1;
        end
      end
      RUN: begin
        busy   = 1'b1;
        mem_en = issue_ok;
        if (xfer && head_last) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr = mem_en ? issue_cnt[ADDR_W-1:0] : '0;

  // Stage p0: read issue
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      issue_cnt <= '0;
      vld_p1    <= 1'b0;
    end else begin
      if (cnt_clr)     issue_cnt <= '0;
      else if (mem_en) issue_cnt <= issue_cnt + 1'b1;
      vld_p1 <= mem_en;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_en) beat_p1 <= issue_cnt;
  end

  // Stage p1: read data returns and is packed into the FIFO
  assign push_data = pack_beat(beat_p1, pix_rdata, wgt_rdata);

  beat_fifo2 #(
    .W (EW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (GlobalReset),
    .push      (vld_p1),
    .push_data (push_data),
    .pop       (xfer),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Output stage: idle buses read as zero for a free-running accumulator
  assign Pixels   = out_valid ? fifo_head[WW +: PW] : '0;
  assign Weights  = out_valid ? fifo_head[0 +: WW]  : '0;
  assign out_last = out_valid && head_last;

endmodule

// File: tb/tb_dot_operand_streamer.sv
// Bench for dot_operand_streamer: two instances (PIXEL_N=10 and 9) share stimulus
// and memory contents and are scored against a per-beat reference model.
module tb_dot_operand_streamer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start;
  logic out_ready;

  logic        busy0, done0, en0, vld0, last0;
  logic [7:0]  addr0;
  logic [19:0] prd0, pix0;
  logic [37:0] wrd0, wgt0;
  logic        busy1, done1, en1, vld1, last1;
  logic [7:0]  addr1;
  logic [19:0] prd1, pix1;
  logic [37:0] wrd1, wgt1;

  logic [19:0] pix_mem [0:255];
  logic [37:0] wgt_mem [0:255];

  dot_operand_streamer u_dut0 (
    .clk(clk), .GlobalReset(rst_n), .start(start), .busy(busy0), .done(done0),
    .mem_en(en0), .mem_addr(addr0), .pix_rdata(prd0), .wgt_rdata(wrd0),
    .Pixels(pix0), .Weights(wgt0), .out_valid(vld0), .out_ready(out_ready),
    .out_last(last0)
  );

  dot_operand_streamer #(.PIXEL_N(9)) u_dut1 (
    .clk(clk), .GlobalReset(rst_n), .start(start), .busy(busy1), .done(done1),
    .mem_en(en1), .mem_addr(addr1), .pix_rdata(prd1), .wgt_rdata(wrd1),
    .Pixels(pix1), .Weights(wgt1), .out_valid(vld1), .out_ready(out_ready),
    .out_last(last1)
  );

  always @(posedge clk) begin
    if (en0) begin prd0 <= pix_mem[addr0]; wrd0 <= wgt_mem[addr0]; end
    if (en1) begin prd1 <= pix_mem[addr1]; wrd1 <= wgt_mem[addr1]; end
  end

  int checks = 0;
  int failures = 0;

  logic [58:0] got0[$];
  logic [58:0] got1[$];
  int issued0, xfer0, maxout0, dones0;
  int issued1, xfer1, maxout1, dones1;
  longint acc0, acc1;
  logic s_en0, s_vld0, s_last0, s_done0, s_busy0;
  logic [7:0] s_addr0;
  logic [19:0] s_pix0, s_pix1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint dot2(input logic [19:0] p, input logic [37:0] w);
    return longint'(p[9:0]) * longint'($signed(w[18:0])) +
           longint'(p[19:10]) * longint'($signed(w[37:19]));
  endfunction

  // Beat b of a PIXEL_N=pn vector, built straight from memory contents.
  function automatic logic [58:0] exp_beat(input int pn, input int b);
    logic [19:0] p;
    logic [37:0] w;
    p = '0;
    w = '0;
    for (int j = 0; j < 2; j++) begin
      if (b * 2 + j < pn) begin
        p[j*10 +: 10] = pix_mem[b][j*10 +: 10];
        w[j*19 +: 19] = wgt_mem[b][j*19 +: 19];
      end
    end
    return {(b == (pn + 1) / 2 - 1), p, w};
  endfunction

  task automatic reset_counts();
    got0.delete(); got1.delete();
    issued0 = 0; xfer0 = 0; maxout0 = 0; dones0 = 0; acc0 = 0;
    issued1 = 0; xfer1 = 0; maxout1 = 0; dones1 = 0; acc1 = 0;
  endtask

  task automatic cycle(input logic st, input logic rdy);
    start = st;
    out_ready = rdy;
    #2;
    s_en0 = en0; s_addr0 = addr0; s_vld0 = vld0; s_last0 = last0;
    s_done0 = done0; s_busy0 = busy0; s_pix0 = pix0; s_pix1 = pix1;
    if (en0) issued0++;
    if (en1) issued1++;
    if (vld0 && rdy) begin got0.push_back({last0, pix0, wgt0}); xfer0++; end
    if (vld1 && rdy) begin got1.push_back({last1, pix1, wgt1}); xfer1++; end
    if (issued0 - xfer0 > maxout0) maxout0 = issued0 - xfer0;
    if (issued1 - xfer1 > maxout1) maxout1 = issued1 - xfer1;
    if (done0) dones0++;
    if (done1) dones1++;
    acc0 += dot2(pix0, wgt0);
    acc1 += dot2(pix1, wgt1);
    chk("done_vs_last0", 64'(done0), 64'(vld0 & rdy & last0));
    chk("done_vs_last1", 64'(done1), 64'(vld1 & rdy & last1));
    if (!vld0) chk("invalid_zero0", 64'({last0, pix0, wgt0}), 64'd0);
    if (!vld1) chk("invalid_zero1", 64'({last1, pix1, wgt1}), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input int vectors);
    chk("nbeats0", 64'(got0.size()), 64'(vectors * 5));
    chk("nbeats1", 64'(got1.size()), 64'(vectors * 5));
    for (int k = 0; k < got0.size() && k < vectors * 5; k++)
      chk($sformatf("beat0_%0d", k), 64'(got0[k]), 64'(exp_beat(10, k % 5)));
    for (int k = 0; k < got1.size() && k < vectors * 5; k++)
      chk($sformatf("beat1_%0d", k), 64'(got1[k]), 64'(exp_beat(9, k % 5)));
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ctl0"}, 64'({busy0, vld0, done0, en0, last0, addr0}), 64'd0);
    chk({tag, "_ctl1"}, 64'({busy1, vld1, done1, en1, last1, addr1}), 64'd0);
    chk({tag, "_pix"},  64'({pix0, pix1}), 64'd0);
    chk({tag, "_wgt0"}, 64'(wgt0), 64'd0);
    chk({tag, "_wgt1"}, 64'(wgt1), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      pix_mem[i] = {10'(i), 10'(i)};
      wgt_mem[i] = {19'h20000, 19'h20000};
    end
    repeat (2) @(posedge clk);
    #3;
    check_quiet("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Idle: nothing issued, buses quiet.
    reset_counts();
    repeat (20) cycle(1'b0, 1'b1);
    chk("idle_issued", 64'(issued0 + issued1), 64'd0);
    chk("idle_beats", 64'(got0.size() + got1.size()), 64'd0);

    // Nominal stream with out_ready high.
    reset_counts();
    for (int c = 0; c < 12; c++) begin
      cycle(c == 0, 1'b1);
      chk($sformatf("nom_en_c%0d", c), 64'(s_en0), 64'(c >= 1 && c <= 5));
      if (c >= 1 && c <= 5) chk($sformatf("nom_addr_c%0d", c), 64'(s_addr0), 64'(c - 1));
      chk($sformatf("nom_vld_c%0d", c), 64'(s_vld0), 64'(c >= 3 && c <= 7));
      if (c >= 3 && c <= 7) chk($sformatf("nom_pix_c%0d", c), 64'(s_pix0[9:0]), 64'(c - 3));
      chk($sformatf("nom_last_c%0d", c), 64'(s_last0), 64'(c == 7));
      chk($sformatf("nom_done_c%0d", c), 64'(s_done0), 64'(c == 7));
      chk($sformatf("nom_busy_c%0d", c), 64'(s_busy0), 64'(c >= 1 && c <= 7));
    end
    check_stream(1);
    chk("nom_dones0", 64'(dones0), 64'd1);
    chk("nom_dones1", 64'(dones1), 64'd1);
    chk("nom_acc0", 64'(acc0 >>> 16), 64'd40);
    chk("nom_acc9", 64'(acc1 >>> 16), 64'd32);
    if (got1.size() == 5) chk("pn9_beat4", 64'(got1[4]), 64'({1'b1, 10'd0, 10'd4, 19'd0, 19'h20000}));

    // Back-pressure on cycles 4-6.
    reset_counts();
    for (int c = 0; c < 14; c++) begin
      cycle(c == 0, !(c >= 4 && c <= 6));
      if (c >= 4 && c <= 6) begin
        chk($sformatf("bp_vld_c%0d", c), 64'(s_vld0), 64'd1);
        chk($sformatf("bp_hold_c%0d", c), 64'(s_pix0), 64'({10'd1, 10'd1}));
      end
    end
    check_stream(1);
    chk("bp_maxout0", 64'(maxout0 <= 2), 64'd1);
    chk("bp_maxout1", 64'(maxout1 <= 2), 64'd1);
    chk("bp_dones0", 64'(dones0), 64'd1);

    // Start while busy is ignored; start right after done is taken.
    reset_counts();
    for (int c = 0; c < 22; c++) cycle(c == 0 || c == 3 || c == 8, 1'b1);
    check_stream(2);
    chk("rs_dones0", 64'(dones0), 64'd2);
    chk("rs_dones1", 64'(dones1), 64'd2);

    // Asynchronous reset mid-vector, then a clean restart from address 0.
    reset_counts();
    for (int c = 0; c < 4; c++) cycle(c == 0, 1'b1);
    start = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("pre_reset_vld", 64'(vld0), 64'd1);
    rst_n = 1'b0;
    #1;
    check_quiet("midreset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    reset_counts();
    for (int c = 0; c < 12; c++) begin
      cycle(c == 0, 1'b1);
      if (c == 1) begin
        chk("post_reset_en", 64'(s_en0), 64'd1);
        chk("post_reset_addr", 64'(s_addr0), 64'd0);
      end
    end
    check_stream(1);
    chk("post_reset_dones", 64'(dones0), 64'd1);

    // Random memory contents and random back-pressure, three vectors.
    for (int i = 0; i < 8; i++) begin
      pix_mem[i] = 20'($urandom);
      wgt_mem[i] = {6'($urandom), 32'($urandom)};
    end
    reset_counts();
    for (int v = 0; v < 3; v++) begin
      int n;
      n = 0;
      cycle(1'b1, 1'($urandom_range(0, 1)));
      while (dones0 < v + 1 && n < 80) begin
        cycle(1'b0, $urandom_range(0, 3) != 0);
        n++;
      end
      chk($sformatf("rand_bound_v%0d", v), 64'(dones0 >= v + 1), 64'd1);
    end
    repeat (3) cycle(1'b0, 1'b1);
    check_stream(3);
    chk("rand_dones1", 64'(dones1), 64'd3);
    chk("rand_maxout0", 64'(maxout0 <= 2), 64'd1);
    chk("rand_maxout1", 64'(maxout1 <= 2), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dot_operand_streamer.md
Name: dot_operand_streamer

Overview:
Transmit-side feeder for the streaming dot-product engine. On a start pulse it reads PIXEL_N pixel/weight pairs from two synchronous-read memories. It packs them into beats of LANES = PARALLEL*BUS_WIDTH elements and drives the engine's Pixels/Weights buses, one beat per accepted cycle. It has valid/ready flow control, zero-fill and end-of-vector marking.

Parameters:
PIXEL_N, 10, elements per dot product
WEIGHT_SIZE, 19, bits per weight (fixed point)
PIXEL_SIZE, 10, bits per pixel
PARALLEL, 2, lanes per beat
BUS_WIDTH, 1, bus multiplier; LANES = PARALLEL*BUS_WIDTH
ADDR_W, 8, memory address width; must satisfy 2^ADDR_W >= BEATS = ceil(PIXEL_N/LANES)

Ports:
clk  in  1  clock, rising edge
GlobalReset  in  1  asynchronous active-low reset
start  in  1  one-cycle request to stream one vector
busy  out  1  high while a vector is in progress
done  out  1  one-cycle pulse when the final beat is accepted
mem_en  out  1  read enable shared by both memories
mem_addr  out  ADDR_W  beat address shared by both memories
pix_rdata  in  LANES*PIXEL_SIZE  pixel word, valid the cycle after mem_en
wgt_rdata  in  LANES*WEIGHT_SIZE  weight word, valid the cycle after mem_en
Pixels  out  LANES*PIXEL_SIZE  lane j at [j*PIXEL_SIZE +: PIXEL_SIZE]
Weights  out  LANES*WEIGHT_SIZE  lane j at [j*WEIGHT_SIZE +: WEIGHT_SIZE]
out_valid  out  1  beat on Pixels/Weights is valid
out_ready  in  1  consumer accepts the beat (transfer = out_valid & out_ready)
out_last  out  1  qualifies the final beat of the vector

Behaviour:
- Reset (GlobalReset=0, asynchronous): FSM returns to IDLE; all outputs are 0; FIFO is flushed; the in-flight read is discarded. This applies mid-vector too, with no partial done.
- FSM states:
  - IDLE: start=1 moves to RUN. Beat counters clear and busy=1 from the next cycle.
  - RUN: issues reads; moves to IDLE on the transfer of the last beat.
  - start while busy is ignored.
- Read issue in RUN: mem_en=1 with mem_addr=issue_cnt when issue_cnt < BEATS and (fifo_count + inflight) < 2. issue_cnt increments on each issue. inflight is 1 in the cycle after an issue.
- Data capture: one cycle after mem_en, {pix_rdata, wgt_rdata} are pushed into a 2-entry FIFO.
  - Lanes with global index beat*LANES + j >= PIXEL_N are forced to 0 in both buses, so a partial last beat is zero-filled.
  - out_last is stored with the entry (beat == BEATS-1).
- Output:
  - out_valid = FIFO non-empty; Pixels/Weights/out_last come from the FIFO head.
  - When out_valid=0, Pixels=0, Weights=0 and out_last=0. A free-running accumulator downstream therefore adds nothing.
- Throughput and latency: with out_ready held high, 1 beat/cycle. The first mem_en is 1 cycle after start; the first out_valid is 2 cycles after mem_en; beats are contiguous.
- Back-pressure: when out_ready=0 the head holds stable. No beat is lost or duplicated, and issue pauses once the FIFO plus in-flight count reaches 2.
- FIFO push and pop in the same cycle are legal; the count is unchanged.
- done=1 in the cycle of the last-beat transfer. busy falls the following cycle. A start in that following cycle is accepted.
- BEATS=1 is legal: the single beat carries out_last=1.

Decomposition:
- Shared package: the LANES and BEATS derivations, a clog2 function, and the FSM state encoding (IDLE=0, RUN=1).
- One sub-module, beat_fifo2: a 2-entry synchronous FIFO, data width LANES*(PIXEL_SIZE+WEIGHT_SIZE)+1, with the same asynchronous active-low reset.

Test Plan:
- Defaults (PIXEL_N=10, LANES=2, BEATS=5). The memory returns pixel word {i,i} and weights 19'h20000 in both lanes at address i. With out_ready=1 and start at cycle 0: mem_en at cycles 1-5 with addr 0-4; out_valid at cycles 3-7 with Pixels lanes = 0..4; out_last and done at cycle 7 only; busy low from cycle 8.
- Same stimulus, out_ready=0 during cycles 4-6: beat 1 held stable through cycle 6, at most 2 reads outstanding; beats 0-4 each delivered exactly once in order; done on the beat-4 transfer.
- PIXEL_N=9: beat 4 has lane 0 = 4/19'h20000 and lane 1 = 0/0; out_last=1. A downstream dot product accumulates 2*(0+0+1+1+2+2+3+3+4) = 32.
- start pulsed again at cycle 3 of a run: ignored, exactly 5 beats and 1 done. A start in the cycle after done is accepted and a second vector streams.
- GlobalReset low at cycle 4 mid-vector: out_valid, busy, done, mem_en and Pixels/Weights are 0 immediately. After release a new start streams beats from address 0.
- Idle check: with no start for 20 cycles, Pixels=Weights=0, out_valid=0 and mem_en=0 throughout.
